// File: rtl/fetch_ctrl_pkg.sv
// fetch_pkg: shared widths, FSM states and queue entry type
// for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
  localparam logic [ADDR_W-1:0] PC_STEP  = 8'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_if: ROM read bus plus the fetch-to-decode
// valid/ready handshake.
interface fetch_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] rom_addy;
  logic [INST_W-1:0] rom_inst;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              id_ready;

  modport master (
    output rom_addy,
    input  rom_inst,
    output if_valid,
    output if_inst,
    output if_pc,
    input  id_ready
  );

  modport slave (
    input  rom_addy,
    output rom_inst,
    input  if_valid,
    input  if_inst,
    input  if_pc,
    output id_ready
  );

endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf: 2-entry FIFO of {pc, inst} between the ROM
// capture point and decode; flush drops all entries.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;

  logic w_push;
  logic w_pop;

  assign w_pop  = pop && (r_cnt != 2'd0);
  assign w_push = push && ((r_cnt != 2'd2) || w_pop);

  assign count = r_cnt;
  assign head  = r_mem[r_rp];

  // pointer/count update; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= wdata;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues ROM reads under a 2-slot
// credit, captures words one cycle later, handles redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] P_RESET_PC = RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_state,
  fetch_if.master           bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_in_flight;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [2:0]        w_credit;
  logic [1:0]        w_count;
  fetch_entry_t      w_head;
  fetch_entry_t      w_wdata;

  assign w_pop   = bus.if_valid && bus.id_ready;
  assign w_push  = r_in_flight && !redirect_valid;
  assign w_wdata = {r_inflight_pc, bus.rom_inst};

  // slots already claimed after this edge's transfer
  assign w_credit = {1'b0, w_count}
                  + {2'b00, r_in_flight}
                  - {2'b00, w_pop};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and issue decision; issue follows the
  // state being entered so the first read goes out at
  // the same edge that leaves IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: if (fetch_en) w_state_nxt = RUN;
      RUN:  if (!fetch_en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_issue = (w_state_nxt == RUN)
           && !redirect_valid
           && (w_credit < 3'd2);
  end

  // pc, in-flight tracking; redirect has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= P_RESET_PC;
      r_inflight_pc <= '0;
      r_in_flight   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc  <= {redirect_pc[ADDR_W-1:2], 2'b00};
      r_in_flight <= 1'b0;
    end else if (w_issue) begin
      r_in_flight   <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
      r_fetch_pc    <= r_fetch_pc + PC_STEP;
    end else begin
      r_in_flight <= 1'b0;
    end
  end

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .count (w_count),
    .head  (w_head)
  );

  assign bus.rom_addy = r_fetch_pc;
  assign bus.if_valid = (w_count != 2'd0);
  assign bus.if_inst  = w_head.inst;
  assign bus.if_pc    = w_head.pc;
  assign if_state     = (r_state == RUN);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vectors against a registered
// ROM model with hand-computed expectations.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       fetch_en;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       if_state;

  fetch_if bus ();

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_state       (if_state),
    .bus            (bus)
  );

  logic [31:0] rom [64];
  logic [39:0] xfer_q [$];
  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous ROM: address sampled at the rising edge
  always @(posedge clk)
    bus.rom_inst <= rom[bus.rom_addy[7:2]];

  // log of completed decode transfers
  always @(posedge clk)
    if (rst_n && bus.if_valid && bus.id_ready)
      xfer_q.push_back({bus.if_pc, bus.if_inst});

  task automatic chk(input string tag,
                     input logic [39:0] got,
                     input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag,
                         input logic [7:0] pc,
                         input logic [31:0] inst);
    chk({tag, "_v"}, {39'd0, bus.if_valid}, 40'd1);
    chk({tag, "_pc"}, {32'd0, bus.if_pc}, {32'd0, pc});
    chk({tag, "_in"}, {8'd0, bus.if_inst}, {8'd0, inst});
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      rom[i] = 32'hA5A5_0000 | i;
    rom[0] = 32'h0045_0693;
    rom[1] = 32'h0010_0713;
    rom[2] = 32'h00b7_6463;
    rom[4] = 32'h0006_a803;
    rom[5] = 32'h0006_8613;
    rom[7] = 32'hffc6_2883;

    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    bus.id_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);

    chk("rst_addr", {32'd0, bus.rom_addy}, 40'h00);
    chk("rst_vld", {39'd0, bus.if_valid}, 40'd0);
    chk("rst_inst", {8'd0, bus.if_inst}, 40'd0);
    chk("rst_pc", {32'd0, bus.if_pc}, 40'd0);
    chk("rst_st", {39'd0, if_state}, 40'd0);

    // straight-line fetch
    fetch_en = 1'b1;
    rst_n    = 1'b1;
    tick();
    chk("t1_e1_vld", {39'd0, bus.if_valid}, 40'd0);
    chk("t1_st", {39'd0, if_state}, 40'd1);
    tick();
    chk_out("t1_a", 8'h00, 32'h0045_0693);
    tick();
    chk_out("t1_b", 8'h04, 32'h0010_0713);
    tick();
    chk_out("t1_c", 8'h08, 32'h00b7_6463);

    // decode stall then release
    rst_pulse();
    tick();
    tick();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("t2_hold", 8'h00, 32'h0045_0693);
    end
    chk("t2_cnt", {38'd0, dut.u_buf.count}, 40'd2);
    chk("t2_addr", {32'd0, bus.rom_addy}, 40'h08);
    xfer_q.delete();
    bus.id_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t2_n", xfer_q.size(), 40'd3);
    if (xfer_q.size() == 3) begin
      chk("t2_x0", xfer_q[0], 40'h00_0045_0693);
      chk("t2_x1", xfer_q[1], 40'h04_0010_0713);
      chk("t2_x2", xfer_q[2], 40'h08_00b7_6463);
    end

    // redirect flushes queued 0x04/0x08
    rst_pulse();
    tick();
    tick();
    tick();
    bus.id_ready = 1'b0;
    tick();
    chk("t3_cnt", {38'd0, dut.u_buf.count}, 40'd2);
    chk("t3_head", {32'd0, bus.if_pc}, 40'h04);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h10;
    tick();
    chk("t3_fl", {39'd0, bus.if_valid}, 40'd0);
    redirect_valid = 1'b0;
    bus.id_ready   = 1'b1;
    tick();
    chk("t3_e1", {39'd0, bus.if_valid}, 40'd0);
    tick();
    chk_out("t3_a", 8'h10, 32'h0006_a803);
    tick();
    chk_out("t3_b", 8'h14, 32'h0006_8613);

    // misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 8'h1E;
    tick();
    chk("t4_addr", {32'd0, bus.rom_addy}, 40'h1C);
    redirect_valid = 1'b0;
    tick();
    tick();
    chk_out("t4", 8'h1C, 32'hffc6_2883);

    // wrap-around at top of ROM
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    chk_out("t5_a", 8'hFC, 32'hA5A5_003F);
    tick();
    chk_out("t5_b", 8'h00, 32'h0045_0693);
    tick();
    chk_out("t5_c", 8'h04, 32'h0010_0713);

    // fetch_en low: drain only
    fetch_en = 1'b0;
    xfer_q.delete();
    tick();
    chk("t6_addr1", {32'd0, bus.rom_addy}, 40'h0C);
    chk("t6_st", {39'd0, if_state}, 40'd0);
    chk_out("t6_d", 8'h08, 32'h00b7_6463);
    tick();
    chk("t6_vld2", {39'd0, bus.if_valid}, 40'd0);
    chk("t6_addr2", {32'd0, bus.rom_addy}, 40'h0C);
    tick();
    chk("t6_vld3", {39'd0, bus.if_valid}, 40'd0);
    chk("t6_addr3", {32'd0, bus.rom_addy}, 40'h0C);
    chk("t6_n", xfer_q.size(), 40'd2);
    if (xfer_q.size() == 2) begin
      chk("t6_x0", xfer_q[0], 40'h04_0010_0713);
      chk("t6_x1", xfer_q[1], 40'h08_00b7_6463);
    end

    // async reset mid-stream
    fetch_en = 1'b1;
    tick();
    tick();
    chk_out("t7", 8'h0C, 32'hA5A5_0003);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_vld", {39'd0, bus.if_valid}, 40'd0);
    chk("t7_addr", {32'd0, bus.rom_addy}, 40'h00);
    chk("t7_pc", {32'd0, bus.if_pc}, 40'h00);
    chk("t7_st", {39'd0, if_state}, 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the synchronous instruction ROM.
- The ROM has an 8-bit byte address and 32-bit word, registered on the rising clock edge, with no enable.
- This block owns the program counter, drives the ROM address and tracks the one-cycle ROM read latency.
- It buffers fetched words in a 2-entry queue and delivers {pc, inst} to decode over a valid/ready handshake; branch/jump redirects from execute flush it.

Parameters:
- ADDR_W, 8: ROM byte-address width.
- INST_W, 32: instruction width.
- RESET_PC, 8'h00: first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  permits new ROM reads.
- redirect_valid  in  1  pc redirect strobe (branch/jump taken).
- redirect_pc  in  ADDR_W  redirect target.
- rom_addy  out  ADDR_W  ROM address; driven directly from the fetch_pc flop.
- rom_inst  in  INST_W  ROM data; valid the cycle after the address was sampled.
- if_valid  out  1  instruction available to decode.
- if_inst  out  INST_W  instruction word (queue head).
- if_pc  out  ADDR_W  byte address of if_inst.
- id_ready  in  1  decode accepts; a transfer occurs when if_valid && id_ready.
- if_state  out  1  0 = IDLE, 1 = RUN (debug).

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc = RESET_PC, so rom_addy = RESET_PC.
  - in_flight = 0, queue count = 0.
  - if_valid = 0, if_inst = 0, if_pc = 0, state = IDLE.
- State machine:
  - IDLE -> RUN when fetch_en=1.
  - RUN -> IDLE when fetch_en=0.
  - A redirect does not change state.
- Issue rule (RUN only): issue at an edge when count + in_flight - pop < 2, where pop = if_valid && id_ready.
  - On issue: in_flight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 256; 0xFC wraps to 0x00).
  - Otherwise: in_flight <= 0 and fetch_pc holds.
- Capture: at any edge where in_flight=1, push {inflight_pc, rom_inst} into the queue.
  - The credit rule guarantees the queue is never full at push.
  - A push and a pop at the same edge are both legal.
- Output timing:
  - if_valid = (count != 0); if_inst and if_pc are the queue head, held stable while if_valid && !id_ready.
  - Latency is 2 edges from issue edge to if_valid high. The first instruction after reset with fetch_en=1 appears after the 2nd rising edge.
  - Sustained throughput is 1 instruction per cycle with id_ready=1.
- Redirect (highest priority): at an edge with redirect_valid=1:
  - count <= 0, in_flight <= 0 (in-flight word discarded).
  - fetch_pc <= {redirect_pc[7:2], 2'b00}; misaligned targets are silently aligned.
  - No issue at that edge. A pop in the same cycle still counts as a completed transfer.
  - The target word is valid at the 2nd edge after the redirect edge, provided fetch_en=1.
- fetch_en=0 stops new issues only; in-flight and queued words still drain to decode.
- Back-to-back redirects: each one overrides fully; only the last target is fetched.
- Reset asserted mid-operation clears everything immediately; no partial outputs are held.

Decomposition:
- Package fetch_pkg:
  - ADDR_W, INST_W, RESET_PC, PC_STEP=4.
  - State enum {IDLE, RUN}.
  - Typedef fetch_entry_t {pc, inst}.
- One sub-module, fetch_buf: 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Async active-low reset.

Test Plan:
- Reset release, fetch_en=1, id_ready=1:
  - if_valid rises after the 2nd edge.
  - Outputs in order: (0x00, 0x00450693), (0x04, 0x00100713), (0x08, 0x00b76463), one per cycle.
- id_ready=0 for 5 cycles once the first word is valid:
  - if_pc=0x00 and if_inst=0x00450693 stay stable.
  - count settles at 2 and rom_addy holds 0x08.
  - On release, 0x00, 0x04, 0x08 are delivered with no loss or duplication.
- redirect_valid pulse with redirect_pc=0x10 while words for 0x04/0x08 are queued:
  - Both are flushed.
  - The next if_valid, 2 edges later, carries (0x10, 0x0006a803), then (0x14, 0x00068613).
- Redirect to 0x1E (misaligned):
  - Fetch starts at 0x1C and delivers 0xffc62883.
- Redirect to 0xFC with fetch_en=1:
  - if_pc sequence 0xFC, 0x00, 0x04 (wrap-around).
- Mid-stream checks:
  - Deassert fetch_en: the queue drains and no new rom_addy advance occurs.
  - Assert rst_n=0 mid-stream: if_valid=0 and rom_addy=0x00 immediately, asynchronously.
